// File: rtl/alu_pkg.sv
// Shared definitions for the ALU + accumulator datapath and its sequencer.
package alu_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int OPW_DEF   = 4;

  // Opcodes the sequencer resolves itself without using the ALU result.
  localparam logic [3:0] OP_CLR = 4'hF;
  localparam logic [3:0] OP_LDB = 4'hE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_acc_sequencer_acc_reg.sv
// Accumulator storage: WIDTH-bit register with sync reset and load enable.
module acc_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d when enabled; reset clears the accumulator.
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/alu_acc_sequencer.sv
// Two-requester sequencer around an external combinational ALU and an
// internal accumulator. Round-robin grant, one operation in flight,
// tagged response held until consumed.
module alu_acc_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int OPW     = OPW_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_operand,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_operand,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_error,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_error,
  output logic             busy
);

  localparam int CNT_W = 4;

  state_t             state, state_nxt;
  logic               rr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [OPW-1:0]     op_q;
  logic [WIDTH-1:0]   operand_q;
  logic               id_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic               rsp_error_q;
  logic [WIDTH-1:0]   acc, acc_d;
  logic               acc_en;
  logic               upd_err;
  logic               grant_any, grant_id;
  logic               exec_last;

  acc_reg #(.WIDTH(WIDTH)) u_acc (
    .clk (clk),
    .rst (rst),
    .en  (acc_en),
    .d   (acc_d),
    .q   (acc)
  );

  // Arbitration: rr_ptr's requester has priority, otherwise the other one.
  always_comb begin
    grant_any = (state == IDLE) && (req0_valid || req1_valid);
    grant_id  = (rr_ptr ? req1_valid : req0_valid) ? rr_ptr : ~rr_ptr;
    exec_last = (state == EXEC) && (cnt == '0);
  end

  assign req0_ready = grant_any && !grant_id;
  assign req1_ready = grant_any &&  grant_id;

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = EXEC;
      EXEC:    if (cnt == '0) state_nxt = WB;
      WB:      if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator update decided on the final EXEC cycle.
  always_comb begin
    acc_en  = 1'b0;
    acc_d   = acc;
    upd_err = 1'b0;
    if (exec_last) begin
      if (op_q == OPW'(OP_CLR)) begin
        acc_en = 1'b1;
        acc_d  = '0;
      end else if (op_q == OPW'(OP_LDB)) begin
        acc_en = 1'b1;
        acc_d  = operand_q;
      end else if (alu_error) begin
        upd_err = 1'b1;
      end else begin
        acc_en = 1'b1;
        acc_d  = alu_result;
      end
    end
  end

  // Control state: FSM, EXEC counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rr_ptr <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_any)
        cnt <= CNT_W'(ALU_LAT - 1);
      else if (state == EXEC && cnt != '0)
        cnt <= cnt - 1'b1;
      if (state == WB && rsp_ready)
        rr_ptr <= ~id_q;
    end
  end

  // Datapath capture: command at grant, response at the end of EXEC.
  always_ff @(posedge clk) begin
    if (grant_any) begin
      op_q      <= grant_id ? req1_op      : req0_op;
      operand_q <= grant_id ? req1_operand : req0_operand;
      id_q      <= grant_id;
    end
    if (exec_last) begin
      rsp_data_q  <= acc_en ? acc_d : acc;
      rsp_error_q <= upd_err;
    end
  end

  // Output drive: ALU operands only during EXEC, response only during WB.
  always_comb begin
    alu_op    = (state == EXEC) ? op_q      : '0;
    alu_b     = (state == EXEC) ? operand_q : '0;
    alu_a     = acc;
    rsp_valid = (state == WB);
    rsp_id    = (state == WB) && id_q;
    rsp_data  = (state == WB) ? rsp_data_q : '0;
    rsp_error = (state == WB) && rsp_error_q;
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Bench for alu_acc_sequencer: directed scenarios plus randomized commands,
// checked against a transaction-level accumulator/round-robin model.
module tb_alu_acc_sequencer;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [15:0] req0_operand, req1_operand;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_result;
  logic        alu_error;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_error, busy;
  logic [15:0] rsp_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [15:0] acc_m;
  logic        rr_m;

  always #5 clk = ~clk;

  alu_acc_sequencer #(.WIDTH(16), .OPW(4), .ALU_LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_op      (req0_op),
    .req0_operand (req0_operand),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_op      (req1_op),
    .req1_operand (req1_operand),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_error    (alu_error),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_error    (rsp_error),
    .busy         (busy)
  );

  // External ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 DIV (error on /0).
  function automatic logic [16:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'd0:    return {1'b0, a + b};
      4'd1:    return {1'b0, a - b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      4'd5:    return (b == 16'd0) ? {1'b1, 16'hFFFF} : {1'b0, a / b};
      default: return {1'b0, 16'hDEAD};
    endcase
  endfunction

  always_comb begin
    {alu_error, alu_result} = alu_fn(alu_op, alu_a, alu_b);
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full command: called at the start of an IDLE cycle (1ns after an edge).
  task automatic do_txn(input logic v0, input logic v1,
                        input logic [3:0] o0, input logic [3:0] o1,
                        input logic [15:0] b0, input logic [15:0] b1,
                        input int hold, input logic keep_valid);
    logic        w;
    logic [3:0]  op;
    logic [15:0] b, exp_acc;
    logic [16:0] r;
    logic        exp_err;
    req0_valid = v0; req0_op = o0; req0_operand = b0;
    req1_valid = v1; req1_op = o1; req1_operand = b1;
    #1;
    w  = (rr_m ? v1 : v0) ? rr_m : ~rr_m;
    op = w ? o1 : o0;
    b  = w ? b1 : b0;
    chk("idle_busy",  32'(busy), 32'd0);
    chk("ready0",     32'(req0_ready), 32'(w == 1'b0));
    chk("ready1",     32'(req1_ready), 32'(w == 1'b1));
    chk("idle_alu_a", 32'(alu_a), 32'(acc_m));
    chk("idle_alu_op", 32'(alu_op), 32'd0);
    chk("idle_alu_b", 32'(alu_b), 32'd0);
    // Expected accumulator after this command
    exp_err = 1'b0;
    if (op == 4'hF)      exp_acc = 16'h0000;
    else if (op == 4'hE) exp_acc = b;
    else begin
      r = alu_fn(op, acc_m, b);
      exp_err = r[16];
      exp_acc = r[16] ? acc_m : r[15:0];
    end
    tick();
    if (!keep_valid) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    for (int i = 0; i < LAT; i++) begin
      chk("exec_busy",  32'(busy), 32'd1);
      chk("exec_rspv",  32'(rsp_valid), 32'd0);
      chk("exec_rdy",   32'({req0_ready, req1_ready}), 32'd0);
      chk("exec_op",    32'(alu_op), 32'(op));
      chk("exec_a",     32'(alu_a), 32'(acc_m));
      chk("exec_b",     32'(alu_b), 32'(b));
      tick();
    end
    rsp_ready = (hold == 0);
    for (int i = 0; i <= hold; i++) begin
      if (i == hold) rsp_ready = 1'b1;
      #1;
      chk("wb_rspv",  32'(rsp_valid), 32'd1);
      chk("wb_id",    32'(rsp_id), 32'(w));
      chk("wb_data",  32'(rsp_data), 32'(exp_acc));
      chk("wb_err",   32'(rsp_error), 32'(exp_err));
      chk("wb_rdy",   32'({req0_ready, req1_ready}), 32'd0);
      chk("wb_acc",   32'(alu_a), 32'(exp_acc));
      tick();
    end
    rsp_ready  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    acc_m = exp_acc;
    rr_m  = ~w;
  endtask

  function automatic logic [3:0] pick_op();
    int r;
    r = $urandom_range(0, 7);
    if (r == 6) return 4'hE;
    if (r == 7) return 4'hF;
    return 4'(r);
  endfunction

  function automatic logic [15:0] pick_b(input logic [3:0] op);
    if (op == 4'd5) return 16'($urandom_range(0, 2));
    return 16'($urandom);
  endfunction

  initial begin
    logic [3:0] o0, o1;
    logic       v0, v1;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req1_op = '0; req0_operand = '0; req1_operand = '0;
    rsp_ready = 1'b0;
    acc_m = 16'h0; rr_m = 1'b0;

    // Reset for two cycles
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rspv", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_acc",  32'(alu_a), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_rspv", 32'(rsp_valid), 32'd0);
    chk("post_rst_rdy",  32'({req0_ready, req1_ready}), 32'd0);
    tick();

    // LDB 0x1234 from requester 0
    do_txn(1'b1, 1'b0, 4'hE, 4'h0, 16'h1234, 16'h0, 0, 1'b0);
    chk("ldb_acc", 32'(alu_a), 32'h1234);

    // CLR from requester 1 leaves rr pointing at requester 0
    do_txn(1'b0, 1'b1, 4'h0, 4'hF, 16'h0, 16'h0, 0, 1'b0);

    // Both valid, ADD 1: grants alternate 0,1,0,1 and acc counts 1..4
    for (int k = 0; k < 4; k++) begin
      chk("rr_expected", 32'(rr_m), 32'(k % 2));
      do_txn(1'b1, 1'b1, 4'h0, 4'h0, 16'd1, 16'd1, 0, 1'b1);
      chk("add_acc", 32'(acc_m), 32'(k + 1));
    end

    // Error leaves acc at 0x00FF
    do_txn(1'b1, 1'b0, 4'hE, 4'h0, 16'h00FF, 16'h0, 0, 1'b0);
    do_txn(1'b0, 1'b1, 4'h0, 4'h5, 16'h0, 16'h0, 0, 1'b0);
    chk("err_acc", 32'(alu_a), 32'h00FF);

    // Response stalled 5 cycles with both requesters waiting
    do_txn(1'b1, 1'b1, 4'h0, 4'h1, 16'h0011, 16'h0022, 5, 1'b1);

    // Reset during EXEC aborts the operation
    req0_valid = 1'b1; req0_op = 4'hE; req0_operand = 16'hBEEF;
    tick();
    req0_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy0", 32'(busy), 32'd0);
    chk("abort_rspv",  32'(rsp_valid), 32'd0);
    chk("abort_acc",   32'(alu_a), 32'd0);
    acc_m = 16'h0; rr_m = 1'b0;
    tick();
    chk("abort_idle_rspv", 32'(rsp_valid), 32'd0);
    do_txn(1'b0, 1'b1, 4'h0, 4'h0, 16'h0, 16'h0042, 0, 1'b0);
    chk("fresh_acc", 32'(alu_a), 32'h0042);

    // Randomized commands
    for (int k = 0; k < 60; k++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      o0 = pick_op();
      o1 = pick_op();
      do_txn(v0, v1, o0, o1, pick_b(o0), pick_b(o1),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
